dec8_to_bin32: RTL and testbench
================================

Name: dec8_to_bin32

Overview:
- Sequential converter from 8-digit packed BCD to 32-bit unsigned binary.
- Inverse of the team's BIN32→DEC8 successive-subtraction converter; reuses its weight table and st/en_conv/ok_conv/ptr_dig handshake.
- Used where keypad or BCD register values must feed binary arithmetic.
- Uses repeated addition: for each digit, the digit's decimal weight is added once per unit of that digit.

Parameters:
CHECK_BCD, 1, 1 = reject digits > 9 at start (err); 0 = no check, digits A–F are accumulated as values 10–15.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset; highest priority
DEC  input  32  packed BCD {D8..D1}; D8 = DEC[31:28] is the most significant digit, D1 = DEC[3:0]; sampled only in the st cycle
st  input  1  start pulse; sampled every clock edge
BIN  output  32  binary result register; updated only on completion
ptr_dig  output  4  current digit pointer, 8..1; 0 when idle or done
en_conv  output  1  conversion in progress
ok_conv  output  1  one-cycle completion pulse; BIN is valid in the same cycle
err  output  1  invalid BCD digit detected at last start (CHECK_BCD=1 only)

Behaviour:
- Reset (rst=1 at an edge): BIN=0, ptr_dig=0, en_conv=0, ok_conv=0, err=0, acc=0, all digit registers cleared. rst overrides st and any conversion in progress.
- Internal state:
  - digit registers d8..d1, 4 bits each;
  - acc, 32 bits (max 99,999,999 fits in 27 bits, so no overflow);
  - weight Nd from ptr_dig: 8→10^7, 7→10^6, …, 1→1, 0→0.
- Start: st=1 and rst=0 at an edge.
  - Load d8..d1 from DEC; set acc=0, ok_conv=0.
  - If CHECK_BCD=1 and any digit > 9: err=1, en_conv=0, ptr_dig=0. BIN is unchanged, no ok_conv pulse follows.
  - Otherwise: err=0, en_conv=1, ptr_dig=8.
- st during a conversion restarts it: the new DEC is loaded and the previous job is discarded without an ok_conv pulse.
- Conversion step, once per edge while en_conv=1 and st=0, where cur = d[ptr_dig]:
  - If cur≠0: acc ← acc+Nd; cur ← cur−1; ptr_dig unchanged.
  - If cur=0 and ptr_dig>1: ptr_dig ← ptr_dig−1.
  - If cur=0 and ptr_dig=1: BIN ← acc, ok_conv ← 1, en_conv ← 0, ptr_dig ← 0.
- ok_conv rules:
  - High for exactly one cycle, simultaneous with the new BIN value.
  - Cleared on the next edge unless another completion occurs.
- Latency: ok_conv is asserted (sum of digits + 8) edges after the start edge.
  - Minimum 8 edges (all digits zero).
  - Maximum 80 edges (99999999).
- Idle (en_conv=0, no st): all registers hold; BIN holds its last result indefinitely.
- Digit registers are consumed during conversion. DEC may change freely after the start edge.
- CHECK_BCD=0: nibbles A–F are accumulated as 10–15 times their weight.
  - Result can reach 166,666,665, which still fits in 32 bits.
  - err stays 0.

Test Plan:
- rst, then st with DEC=32'h00000000 → en_conv=1, ptr_dig steps 8→1, ok_conv pulses 8 edges after start, BIN=0, err=0.
- st with DEC=32'h12345678 → ok_conv exactly 44 edges after start (36+8), BIN=32'h00BC614E, en_conv falls with ok_conv, ptr_dig=0.
- st with DEC=32'h99999999 → ok_conv at edge 80, BIN=32'h05F5E0FF; then st with 32'h00000001 → ok_conv at edge 9, BIN=1.
- CHECK_BCD=1, st with DEC=32'h1234A678 after a prior BIN=12345678 → err=1, en_conv=0, no ok_conv within 100 cycles, BIN stays 32'h00BC614E; then a valid st clears err.
- st with 32'h99999999, second st with 32'h00000042 at edge 20 → no pulse for the first job; ok_conv 14 edges after the second st (6+8), BIN=42.
- st with 32'h55555555, rst asserted at edge 10 → all outputs 0 next edge, no ok_conv; later st with 32'h00000007 → BIN=7 at edge 15.

Source files
------------

// File: rtl/dec8_to_bin32_if.sv
// dec8_to_bin32_if: start/data/result bundle; master drives DEC/st, slave returns BIN and status
interface dec8_to_bin32_if;
  logic [31:0] DEC;
  logic        st;
  logic [31:0] BIN;
  logic [3:0]  ptr_dig;
  logic        en_conv;
  logic        ok_conv;
  logic        err;
  modport master (output DEC, st, input BIN, ptr_dig, en_conv, ok_conv, err);
  modport slave (input DEC, st, output BIN, ptr_dig, en_conv, ok_conv, err);
endinterface

// File: rtl/dec8_to_bin32.sv
// dec8_to_bin32: packed 8-digit BCD to 32-bit binary by repeated weight addition; clk, rst, bus (DEC/st in, BIN/ptr_dig/en_conv/ok_conv/err out)
module dec8_to_bin32 #(
  parameter bit CHECK_BCD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  dec8_to_bin32_if.slave        bus
);
  localparam logic [7:0][31:0] W = {32'd10000000, 32'd1000000, 32'd100000, 32'd10000,
                                    32'd1000, 32'd100, 32'd10, 32'd1};
  logic [7:0][3:0] d_q, d_d;
  logic [31:0] acc_q, acc_d, bin_q, bin_d, nd;
  logic [3:0] ptr_q, ptr_d, cur;
  logic [2:0] idx;
  logic en_q, en_d, ok_q, ok_d, err_q, err_d, bad;
  // ptr_dig 8..1 maps to digit slot 7..0
  assign idx = ptr_q[2:0] - 3'd1;
  assign cur = d_q[idx];
  assign nd = (ptr_q == 4'd0) ? 32'd0 : W[idx];
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < 8; i++) if (bus.DEC[4*i +: 4] > 4'd9) bad = CHECK_BCD;
  end
  always_comb begin
    d_d = d_q;
    acc_d = acc_q;
    bin_d = bin_q;
    ptr_d = ptr_q;
    en_d = en_q;
    ok_d = 1'b0;
    err_d = err_q;
    if (bus.st) begin
      d_d = bus.DEC;
      acc_d = '0;
      err_d = bad;
      en_d = !bad;
      ptr_d = bad ? 4'd0 : 4'd8;
    end else if (en_q) begin
      if (cur != 4'd0) begin
        acc_d = acc_q + nd;
        d_d[idx] = cur - 4'd1;
      end else if (ptr_q > 4'd1) begin
        ptr_d = ptr_q - 4'd1;
      end else begin
        bin_d = acc_q;
        ok_d = 1'b1;
        en_d = 1'b0;
        ptr_d = 4'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      acc_q <= '0;
      bin_q <= '0;
      ptr_q <= '0;
      en_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      d_q <= d_d;
      acc_q <= acc_d;
      bin_q <= bin_d;
      ptr_q <= ptr_d;
      en_q <= en_d;
      ok_q <= ok_d;
      err_q <= err_d;
    end
  end
  assign bus.BIN = bin_q;
  assign bus.ptr_dig = ptr_q;
  assign bus.en_conv = en_q;
  assign bus.ok_conv = ok_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_dec8_to_bin32.sv
// tb_dec8_to_bin32: table-driven and directed checks of both BCD-checking and non-checking converters
module tb_dec8_to_bin32;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  dec8_to_bin32_if b1();
  dec8_to_bin32_if b0();
  assign b0.DEC = b1.DEC;
  assign b0.st = b1.st;
  dec8_to_bin32 #(.CHECK_BCD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  dec8_to_bin32 #(.CHECK_BCD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] dec;
    logic [31:0] bin;
    int          lat;
    bit          chk;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask
  task automatic start(input logic [31:0] dec);
    b1.DEC = dec;
    b1.st = 1'b1;
    @(posedge clk);
    #1;
    b1.st = 1'b0;
  endtask
  task automatic wait_ok(input int exp_lat, input logic [31:0] exp_bin, input bit sel_chk);
    int n = 0;
    logic ok;
    for (int i = 1; i <= 200; i++) begin
      ok = sel_chk ? b1.ok_conv : b0.ok_conv;
      if (ok) break;
      @(posedge clk);
      #1;
      n = i;
    end
    ok = sel_chk ? b1.ok_conv : b0.ok_conv;
    chk("ok_seen", {31'd0, ok}, 32'd1);
    chk("latency", n, exp_lat);
    chk("bin", sel_chk ? b1.BIN : b0.BIN, exp_bin);
    chk("en_at_done", {31'd0, sel_chk ? b1.en_conv : b0.en_conv}, 32'd0);
    chk("ptr_at_done", {28'd0, sel_chk ? b1.ptr_dig : b0.ptr_dig}, 32'd0);
    chk("err_at_done", {31'd0, sel_chk ? b1.err : b0.err}, 32'd0);
    @(posedge clk);
    #1;
    chk("ok_one_cycle", {31'd0, sel_chk ? b1.ok_conv : b0.ok_conv}, 32'd0);
    chk("bin_hold", sel_chk ? b1.BIN : b0.BIN, exp_bin);
  endtask
  initial begin
    int pulses;
    vecs[0] = '{32'h00000000, 32'd0, 8, 1'b1};
    vecs[1] = '{32'h12345678, 32'd12345678, 44, 1'b1};
    vecs[2] = '{32'h99999999, 32'd99999999, 80, 1'b1};
    vecs[3] = '{32'h00000001, 32'd1, 9, 1'b1};
    vecs[4] = '{32'h90000009, 32'd90000009, 26, 1'b1};
    vecs[5] = '{32'h0000000F, 32'd15, 23, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'd166666665, 128, 1'b0};
    b1.DEC = '0;
    b1.st = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", b1.BIN, 32'd0);
    chk("rst_ptr", {28'd0, b1.ptr_dig}, 32'd0);
    chk("rst_en", {31'd0, b1.en_conv}, 32'd0);
    chk("rst_ok", {31'd0, b1.ok_conv}, 32'd0);
    chk("rst_err", {31'd0, b1.err}, 32'd0);
    rst = 1'b0;
    foreach (vecs[k]) begin
      start(vecs[k].dec);
      chk("en_after_st", {31'd0, vecs[k].chk ? b1.en_conv : b0.en_conv}, 32'd1);
      chk("ptr_after_st", {28'd0, vecs[k].chk ? b1.ptr_dig : b0.ptr_dig}, 32'd8);
      wait_ok(vecs[k].lat, vecs[k].bin, vecs[k].chk);
    end
    start(32'h12345678);
    wait_ok(44, 32'd12345678, 1'b1);
    start(32'h1234A678);
    chk("bad_err", {31'd0, b1.err}, 32'd1);
    chk("bad_en", {31'd0, b1.en_conv}, 32'd0);
    chk("bad_ptr", {28'd0, b1.ptr_dig}, 32'd0);
    pulses = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (b1.ok_conv) pulses++;
    end
    chk("bad_no_ok", pulses, 0);
    chk("bad_bin_kept", b1.BIN, 32'd12345678);
    chk("bad_err_held", {31'd0, b1.err}, 32'd1);
    start(32'h00000003);
    chk("err_cleared", {31'd0, b1.err}, 32'd0);
    wait_ok(11, 32'd3, 1'b1);
    start(32'h99999999);
    pulses = 0;
    repeat (19) begin
      @(posedge clk);
      #1;
      if (b1.ok_conv) pulses++;
    end
    start(32'h00000042);
    chk("restart_no_ok", pulses, 0);
    wait_ok(14, 32'd42, 1'b1);
    start(32'h55555555);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", {31'd0, b1.en_conv}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_bin", b1.BIN, 32'd0);
    chk("mid_rst_ptr", {28'd0, b1.ptr_dig}, 32'd0);
    chk("mid_rst_en", {31'd0, b1.en_conv}, 32'd0);
    chk("mid_rst_ok", {31'd0, b1.ok_conv}, 32'd0);
    chk("mid_rst_err", {31'd0, b1.err}, 32'd0);
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (b1.ok_conv) pulses++;
    end
    chk("rst_no_ok", pulses, 0);
    start(32'h00000007);
    wait_ok(15, 32'd7, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
